// File: rtl/dimm_cmd_responder.sv
// DIMM-side DDR5 command responder: decodes two-cycle ACT/RD/WR pairs and
// single-cycle PRE/REF, tracks 32 banks, flags protocol and timing errors,
// and returns read/write completions after fixed latencies.
module dimm_cmd_responder #(
    parameter int TRCD = 4,
    parameter int TRP  = 4,
    parameter int TCL  = 6,
    parameter int TCWD = 5,
    parameter int TRFC = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [2:0]  cmd_bg,
    input  logic [1:0]  cmd_ba,
    input  logic [15:0] cmd_row,
    input  logic [5:0]  cmd_col,
    output logic        rd_done,
    output logic [2:0]  rd_bg,
    output logic [1:0]  rd_ba,
    output logic [5:0]  rd_col,
    output logic        wr_done,
    output logic [2:0]  wr_bg,
    output logic [1:0]  wr_ba,
    output logic [5:0]  wr_col,
    output logic [31:0] bank_open,
    output logic        err_valid,
    output logic [2:0]  err_code
);

    localparam logic [2:0] OP_ACT0 = 3'd0;
    localparam logic [2:0] OP_ACT1 = 3'd1;
    localparam logic [2:0] OP_RD0  = 3'd2;
    localparam logic [2:0] OP_RD1  = 3'd3;
    localparam logic [2:0] OP_WR0  = 3'd4;
    localparam logic [2:0] OP_WR1  = 3'd5;
    localparam logic [2:0] OP_PRE  = 3'd6;
    localparam logic [2:0] OP_REF  = 3'd7;

    // Timers are checked against zero on the cycle a command arrives, so a
    // load of N-1 makes the bank usable exactly N cycles after the load.
    localparam logic [7:0] TRCD_LOAD = 8'(TRCD - 1);
    localparam logic [7:0] TRP_LOAD  = 8'(TRP - 1);
    localparam logic [9:0] TRFC_LOAD = 10'(TRFC);

    typedef enum logic [2:0] {IDLE, EXP_ACT1, EXP_RD1, EXP_WR1, REFRESH} state_t;

    state_t              state_reg;
    logic                ready_reg;
    logic [9:0]          ref_cnt_reg;
    logic [2:0]          pend_bg_reg;
    logic [1:0]          pend_ba_reg;
    logic [15:0]         pend_row_reg;
    logic [5:0]          pend_col_reg;
    logic [31:0]         open_reg;
    logic [15:0]         row_reg [32];
    logic                err_valid_reg;
    logic [2:0]          err_code_reg;
    logic [TCL-1:0][11:0]  rd_line_reg;
    logic [TCWD-1:0][11:0] wr_line_reg;

    logic        accept;
    logic [4:0]  sel;
    logic [31:0] timer_zero;
    logic        same_bank;
    logic [2:0]  err_next;
    state_t      state_next;
    logic        latch_pend;
    logic        set_open;
    logic        clr_open;
    logic        load_timer;
    logic [7:0]  load_val;
    logic        push_rd;
    logic        push_wr;
    logic        start_ref;
    logic [11:0] rd_entry;
    logic [11:0] wr_entry;

    assign accept    = cmd_valid && ready_reg;
    assign sel       = {cmd_bg, cmd_ba};
    assign same_bank = (cmd_bg == pend_bg_reg) && (cmd_ba == pend_ba_reg);

    // Command decode: legality on first halves, state actions on second halves
    always_comb begin
        err_next   = 3'd0;
        state_next = state_reg;
        latch_pend = 1'b0;
        set_open   = 1'b0;
        clr_open   = 1'b0;
        load_timer = 1'b0;
        load_val   = TRP_LOAD;
        push_rd    = 1'b0;
        push_wr    = 1'b0;
        start_ref  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_ACT0: begin
                            if (open_reg[sel])        err_next = 3'd2;
                            else if (!timer_zero[sel]) err_next = 3'd4;
                            else begin
                                state_next = EXP_ACT1;
                                latch_pend = 1'b1;
                            end
                        end
                        OP_RD0, OP_WR0: begin
                            if (!open_reg[sel])        err_next = 3'd3;
                            else if (!timer_zero[sel]) err_next = 3'd4;
                            else begin
                                state_next = (cmd_op == OP_RD0) ? EXP_RD1 : EXP_WR1;
                                latch_pend = 1'b1;
                            end
                        end
                        OP_PRE: begin
                            // A closed bank still in tRP keeps its running timer
                            clr_open   = 1'b1;
                            load_timer = open_reg[sel] || timer_zero[sel];
                            load_val   = TRP_LOAD;
                        end
                        OP_REF: begin
                            if ((|open_reg) || !(&timer_zero)) err_next = 3'd5;
                            else begin
                                start_ref  = 1'b1;
                                state_next = REFRESH;
                            end
                        end
                        default: err_next = 3'd1;
                    endcase
                end
            end
            EXP_ACT1: begin
                state_next = IDLE;
                if (accept && cmd_op == OP_ACT1 && same_bank && cmd_row == pend_row_reg) begin
                    set_open   = 1'b1;
                    load_timer = 1'b1;
                    load_val   = TRCD_LOAD;
                end else begin
                    err_next = 3'd1;
                end
            end
            EXP_RD1: begin
                state_next = IDLE;
                if (accept && cmd_op == OP_RD1 && same_bank && cmd_col == pend_col_reg)
                    push_rd = 1'b1;
                else
                    err_next = 3'd1;
            end
            EXP_WR1: begin
                state_next = IDLE;
                if (accept && cmd_op == OP_WR1 && same_bank && cmd_col == pend_col_reg)
                    push_wr = 1'b1;
                else
                    err_next = 3'd1;
            end
            default: state_next = REFRESH;
        endcase
    end

    // Decoder FSM, refresh window, open-bank bits and error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ready_reg     <= 1'b0;
            ref_cnt_reg   <= '0;
            pend_bg_reg   <= '0;
            pend_ba_reg   <= '0;
            pend_row_reg  <= '0;
            pend_col_reg  <= '0;
            open_reg      <= '0;
            err_valid_reg <= 1'b0;
            err_code_reg  <= 3'd0;
        end else begin
            err_valid_reg <= (err_next != 3'd0);
            err_code_reg  <= err_next;
            if (latch_pend) begin
                pend_bg_reg  <= cmd_bg;
                pend_ba_reg  <= cmd_ba;
                pend_row_reg <= cmd_row;
                pend_col_reg <= cmd_col;
            end
            if (set_open) open_reg[sel] <= 1'b1;
            if (clr_open) open_reg[sel] <= 1'b0;
            if (state_reg == REFRESH) begin
                if (ref_cnt_reg == 10'd1) begin
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end else begin
                    ref_cnt_reg <= ref_cnt_reg - 10'd1;
                end
            end else begin
                state_reg <= state_next;
                ready_reg <= !start_ref;
                if (start_ref) ref_cnt_reg <= TRFC_LOAD;
            end
        end
    end

    // Open-row storage, written when an activate completes
    always_ff @(posedge clk) begin
        if (set_open) row_reg[sel] <= cmd_row;
    end

    // Per-bank tRCD/tRP timers, saturating down-counters
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_bank
            logic [7:0] timer_reg;
            always_ff @(posedge clk) begin
                if (!rst_n)
                    timer_reg <= 8'd0;
                else if (load_timer && sel == 5'(gi))
                    timer_reg <= load_val;
                else if (timer_reg != 8'd0)
                    timer_reg <= timer_reg - 8'd1;
            end
            assign timer_zero[gi] = (timer_reg == 8'd0);
        end
    endgenerate

    assign rd_entry = push_rd ? {1'b1, cmd_bg, cmd_ba, cmd_col} : 12'd0;
    assign wr_entry = push_wr ? {1'b1, cmd_bg, cmd_ba, cmd_col} : 12'd0;

    // Completion delay lines; they keep shifting through refresh
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_line_reg <= '0;
            wr_line_reg <= '0;
        end else begin
            rd_line_reg <= {rd_line_reg[TCL-2:0], rd_entry};
            wr_line_reg <= {wr_line_reg[TCWD-2:0], wr_entry};
        end
    end

    assign {rd_done, rd_bg, rd_ba, rd_col} = rd_line_reg[TCL-1];
    assign {wr_done, wr_bg, wr_ba, wr_col} = wr_line_reg[TCWD-1];
    assign cmd_ready = ready_reg;
    assign bank_open = open_reg;
    assign err_valid = err_valid_reg;
    assign err_code  = err_code_reg;

endmodule
